// File: rtl/rsm_pkg.sv
// rsm_pkg
// Shared definitions for the Simple RISC Machine control unit:
// FSM state encoding, opcode/op field values, ALU operation codes,
// one-hot write-back select codes and immediate sign-extension helpers.
package rsm_pkg;

    typedef enum logic [2:0] {
        S_WAIT   = 3'd0,
        S_DECODE = 3'd1,
        S_GET_A  = 3'd2,
        S_GET_B  = 3'd3,
        S_EXEC   = 3'd4,
        S_WR_REG = 3'd5,
        S_WR_IMM = 3'd6
    } state_t;

    localparam logic [2:0] OPC_MOV = 3'b110;
    localparam logic [2:0] OPC_ALU = 3'b101;

    localparam logic [1:0] OP_MOV_REG = 2'b00;
    localparam logic [1:0] OP_MOV_IMM = 2'b10;
    localparam logic [1:0] OP_ADD     = 2'b00;
    localparam logic [1:0] OP_CMP     = 2'b01;
    localparam logic [1:0] OP_AND     = 2'b10;
    localparam logic [1:0] OP_MVN     = 2'b11;

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_AND  = 2'b10;
    localparam logic [1:0] ALU_NOTB = 2'b11;

    localparam logic [3:0] VSEL_MDATA  = 4'b1000;
    localparam logic [3:0] VSEL_SXIMM8 = 4'b0100;
    localparam logic [3:0] VSEL_PC     = 4'b0010;
    localparam logic [3:0] VSEL_C      = 4'b0001;

    function automatic logic [15:0] sign_extend5(input logic [4:0] imm);
        return {{11{imm[4]}}, imm};
    endfunction

    function automatic logic [15:0] sign_extend8(input logic [7:0] imm);
        return {{8{imm[7]}}, imm};
    endfunction

endpackage

// File: rtl/rsm_instr_decoder.sv
// rsm_instr_decoder
// Purely combinational split of the instruction register into its fields.
// Ports:
//   ir        in  16  instruction register contents
//   opcode    out 3   IR[15:13]
//   op        out 2   IR[12:11]
//   rn/rd/rm  out 3   register indices IR[10:8], IR[7:5], IR[2:0]
//   sh        out 2   shift field IR[4:3]
//   sximm5    out 16  sign-extended IR[4:0]
//   sximm8    out 16  sign-extended IR[7:0]
//   undefined out 1   instruction is not one of MOV imm/reg, ADD, CMP, AND, MVN
module rsm_instr_decoder
    import rsm_pkg::*;
(
    input  logic [15:0] ir,
    output logic [2:0]  opcode,
    output logic [1:0]  op,
    output logic [2:0]  rn,
    output logic [2:0]  rd,
    output logic [2:0]  rm,
    output logic [1:0]  sh,
    output logic [15:0] sximm5,
    output logic [15:0] sximm8,
    output logic        undefined
);

    assign opcode = ir[15:13];
    assign op     = ir[12:11];
    assign rn     = ir[10:8];
    assign rd     = ir[7:5];
    assign sh     = ir[4:3];
    assign rm     = ir[2:0];
    assign sximm5 = sign_extend5(ir[4:0]);
    assign sximm8 = sign_extend8(ir[7:0]);

    // Every op value of the ALU opcode is defined; MOV only has op 00 and 10.
    assign undefined = !((opcode == OPC_ALU) ||
                         ((opcode == OPC_MOV) &&
                          ((op == OP_MOV_IMM) || (op == OP_MOV_REG))));

endmodule

// File: rtl/rsm_controller.sv
// rsm_controller
// Control unit for the Simple RISC Machine: holds the instruction register
// and sequences the datapath through read, execute and write-back steps.
// Ports:
//   clk, reset        clock (rising edge) and asynchronous active-high reset
//   in, load          instruction word and capture strobe (honoured in WAIT only)
//   s                 start request, sampled in WAIT
//   w                 high while waiting for the next instruction
//   readnum/writenum  register file read/write indices
//   write             register file write enable
//   loada/loadb/loadc/loads  datapath register load enables
//   asel/bsel         ALU operand selects (zero for A, sximm5 for B)
//   shift, ALUop      shifter and ALU operation
//   vsel              one-hot write-back source select
//   sximm8, sximm5    sign-extended immediates from the IR
module rsm_controller
    import rsm_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] in,
    input  logic        load,
    input  logic        s,
    output logic        w,
    output logic [2:0]  readnum,
    output logic [2:0]  writenum,
    output logic        write,
    output logic        loada,
    output logic        loadb,
    output logic        asel,
    output logic        bsel,
    output logic [1:0]  shift,
    output logic [1:0]  ALUop,
    output logic        loadc,
    output logic        loads,
    output logic [3:0]  vsel,
    output logic [15:0] sximm8,
    output logic [15:0] sximm5
);

    state_t      state;
    logic [15:0] ir;
    logic [2:0]  opcode;
    logic [1:0]  op;
    logic [2:0]  rn;
    logic [2:0]  rd;
    logic [2:0]  rm;
    logic [1:0]  sh;
    logic        undefined;
    logic        is_mov;
    logic        is_cmp;

    rsm_instr_decoder u_decoder (
        .ir        (ir),
        .opcode    (opcode),
        .op        (op),
        .rn        (rn),
        .rd        (rd),
        .rm        (rm),
        .sh        (sh),
        .sximm5    (sximm5),
        .sximm8    (sximm8),
        .undefined (undefined)
    );

    assign is_mov = (opcode == OPC_MOV);
    assign is_cmp = (opcode == OPC_ALU) && (op == OP_CMP);

    // The IR only changes while waiting, so fields stay stable for the
    // whole instruction even if the host keeps pulsing load.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ir <= 16'h0000;
        end else if (state == S_WAIT && load) begin
            ir <= in;
        end
    end

    // Outputs are registered: each transition loads the Moore outputs that
    // belong to the state being entered, so they are glitch-free and line up
    // with the state register. Anything not set below falls back to idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_WAIT;
            w        <= 1'b1;
            readnum  <= 3'b000;
            writenum <= 3'b000;
            write    <= 1'b0;
            loada    <= 1'b0;
            loadb    <= 1'b0;
            asel     <= 1'b0;
            bsel     <= 1'b0;
            shift    <= 2'b00;
            ALUop    <= ALU_ADD;
            loadc    <= 1'b0;
            loads    <= 1'b0;
            vsel     <= VSEL_C;
        end else begin
            w        <= 1'b0;
            readnum  <= 3'b000;
            writenum <= 3'b000;
            write    <= 1'b0;
            loada    <= 1'b0;
            loadb    <= 1'b0;
            asel     <= 1'b0;
            bsel     <= 1'b0;
            shift    <= 2'b00;
            ALUop    <= ALU_ADD;
            loadc    <= 1'b0;
            loads    <= 1'b0;
            vsel     <= VSEL_C;
            case (state)
                S_WAIT: begin
                    if (s) begin
                        state <= S_DECODE;
                    end else begin
                        state <= S_WAIT;
                        w     <= 1'b1;
                    end
                end
                S_DECODE: begin
                    if (undefined) begin
                        state <= S_WAIT;
                        w     <= 1'b1;
                    end else if (is_mov && op == OP_MOV_IMM) begin
                        state    <= S_WR_IMM;
                        writenum <= rn;
                        vsel     <= VSEL_SXIMM8;
                        write    <= 1'b1;
                    end else if (is_mov || op == OP_MVN) begin
                        // Single-operand instructions never need Rn.
                        state   <= S_GET_B;
                        readnum <= rm;
                        loadb   <= 1'b1;
                    end else begin
                        state   <= S_GET_A;
                        readnum <= rn;
                        loada   <= 1'b1;
                    end
                end
                S_GET_A: begin
                    state   <= S_GET_B;
                    readnum <= rm;
                    loadb   <= 1'b1;
                end
                S_GET_B: begin
                    state <= S_EXEC;
                    shift <= sh;
                    // MOV reg passes the shifted B through as 0 + B.
                    if (is_mov) begin
                        ALUop <= ALU_ADD;
                        asel  <= 1'b1;
                    end else begin
                        ALUop <= op;
                    end
                    if (is_cmp) begin
                        loads <= 1'b1;
                    end else begin
                        loadc <= 1'b1;
                    end
                end
                S_EXEC: begin
                    if (is_cmp) begin
                        state <= S_WAIT;
                        w     <= 1'b1;
                    end else begin
                        state    <= S_WR_REG;
                        writenum <= rd;
                        vsel     <= VSEL_C;
                        write    <= 1'b1;
                    end
                end
                default: begin
                    state <= S_WAIT;
                    w     <= 1'b1;
                end
            endcase
        end
    end

endmodule
